// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_pkg
// Purpose  : Shared types and constants for the RISC-V-lite front end.
// Revision : 1.0
// ============================================================================
package rv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } if_id_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Synchronous FIFO of {instr, pc} pairs; flush has priority.
// Revision : 1.0
// ============================================================================
module fetch_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  if_id_t                 i_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output if_id_t                 o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int             AW         = $clog2(DEPTH);
    localparam logic [AW:0]    c_full_cnt = (AW+1)'(DEPTH);

    if_id_t        r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != c_full_cnt) || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == c_full_cnt);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage: PC, imem req/gnt/rvalid, prefetch FIFO.
//            Optional macro FETCH_CNT_EN adds the fetch_cnt output.
// Revision : 1.0
// ============================================================================
module fetch_unit
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
`ifdef FETCH_CNT_EN
    ,
    output logic [31:0] fetch_cnt
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t r_state, w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  r_rsp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop;
    logic [CW-1:0] w_drop_nxt;
    logic [CW-1:0] w_out_nxt;
    logic [CW-1:0] w_inflight;
    logic [CW-1:0] w_count;
    logic [31:0]  w_redirect_pc;
    logic         w_grant;
    logic         w_push;
    logic         w_pop;
    logic         w_full;
    logic         w_empty;
    if_id_t       w_head;
    if_id_t       w_push_data;

    assign w_redirect_pc = word_align(redirect_pc);
    assign w_grant       = imem_req && imem_gnt;
    assign w_pop         = id_valid && id_ready;
    assign w_push        = imem_rvalid && (r_state == RUN) && (r_drop == '0) && !redirect;
    assign w_out_nxt     = r_outstanding + CW'(w_grant) - CW'(imem_rvalid);
    assign w_push_data   = '{instr: imem_rdata, pc: r_rsp_pc};

    // A slot freed by this cycle's pop is reusable immediately, which keeps
    // single-cycle memory streaming at one instruction per cycle.
    assign w_inflight = r_outstanding + w_count - CW'(w_pop);
    assign imem_req   = !rst && (r_state == RUN) && (w_inflight < CW'(FIFO_DEPTH));
    assign imem_addr  = r_pc;

    always_comb begin
        w_state_nxt = r_state;
        w_drop_nxt  = r_drop;
        case (r_state)
            RUN: begin
                if (redirect) begin
                    w_drop_nxt = w_out_nxt;
                    if (w_out_nxt != '0) w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_rvalid) begin
                    w_drop_nxt = r_drop - CW'(1);
                    if (r_drop == CW'(1)) w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RUN;
            r_pc          <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_drop        <= w_drop_nxt;
            r_outstanding <= w_out_nxt;
            if (redirect)     r_pc <= w_redirect_pc;
            else if (w_grant) r_pc <= r_pc + 32'd4;
            if (redirect)     r_rsp_pc <= w_redirect_pc;
            else if (w_push)  r_rsp_pc <= r_rsp_pc + 32'd4;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign id_valid = !w_empty;
    assign id_instr = id_valid ? w_head.instr : NOP_INSTR;
    assign id_pc    = id_valid ? w_head.pc : r_rsp_pc;

    always_ff @(posedge clk) begin
        if (!rst) assert (!(w_push && w_full && !w_pop));
    end

`ifdef FETCH_CNT_EN
    logic [31:0] r_fetch_cnt;

    always_ff @(posedge clk) begin
        if (rst)        r_fetch_cnt <= '0;
        else if (w_pop) r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end

    assign fetch_cnt = r_fetch_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// Bench for fetch_unit: in-order memory model with configurable latency,
// vector table for streaming/back-pressure plus directed redirect sequences.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
`ifdef FETCH_CNT_EN
    logic [31:0] fetch_cnt;
`endif

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc)
`ifdef FETCH_CNT_EN
        ,
        .fetch_cnt   (fetch_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic        rst_before;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    mreq_t mq[$];
    vec_t  vecs [13];
    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc      = 0;
    int    lat      = 1;
    int    n_grants = 0;
    int    n_accept = 0;
    logic  gnt_en   = 1'b1;

    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_instr;
    logic [31:0] s_pc;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return ~a;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, sample outputs before the edge, update memory model.
    task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
        logic        g;
        logic [31:0] ga;
        logic        rv;
        id_ready    = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        imem_gnt    = gnt_en;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = instr_of(mq[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        #1;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = id_valid;
        s_instr = id_instr;
        s_pc    = id_pc;
        g       = imem_req && imem_gnt;
        ga      = imem_addr;
        rv      = imem_rvalid;
        if (id_valid && rdy) n_accept++;
        @(posedge clk);
        if (rv) void'(mq.pop_front());
        if (g) begin
            mq.push_back('{addr: ga, due: cyc + lat});
            n_grants++;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        id_ready    = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        mq.delete();
        @(posedge clk);
        @(negedge clk);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'b0, id_valid}, 32'd0);
        check("rst_instr", id_instr, NOP);
        check("rst_pc", id_pc, 32'h0);
        rst      = 1'b0;
        n_grants = 0;
        n_accept = 0;
        gnt_en   = 1'b1;
    endtask

    task automatic wait_valid(input string nm, input logic [31:0] exp_pc);
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b0, 32'h0);
            if (s_valid) break;
        end
        check({nm, "_valid"}, {31'b0, s_valid}, 32'd1);
        check({nm, "_pc"}, s_pc, exp_pc);
        check({nm, "_instr"}, s_instr, instr_of(exp_pc));
    endtask

    initial begin
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        id_ready    = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;

        // Streaming with single-cycle memory, then hold id_ready low from reset.
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h04, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h08, 1'b1, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h08, 1'b1, 32'h0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h08, 1'b1, 32'h0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8};

        lat = 1;
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].rst_before) do_reset();
            step(vecs[i].rdy, 1'b0, 32'h0);
            check($sformatf("v%0d_req", i), {31'b0, s_req}, {31'b0, vecs[i].req});
            check($sformatf("v%0d_addr", i), s_addr, vecs[i].addr);
            check($sformatf("v%0d_valid", i), {31'b0, s_valid}, {31'b0, vecs[i].valid});
            check($sformatf("v%0d_instr", i), s_instr, vecs[i].valid ? instr_of(vecs[i].pc) : NOP);
            if (vecs[i].valid) check($sformatf("v%0d_pc", i), s_pc, vecs[i].pc);
            if (i == 9) check("hold_grants", n_grants, 2);
        end

        // Latency 3, redirect to 0x100 with two requests outstanding.
        do_reset();
        lat = 3;
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h100);
        check("rd1_req_at_redirect", {31'b0, s_req}, 32'd0);
        step(1'b1, 1'b0, 32'h0);
        check("rd1_drain_req", {31'b0, s_req}, 32'd0);
        check("rd1_drain_addr", s_addr, 32'h100);
        check("rd1_drain_valid", {31'b0, s_valid}, 32'd0);
        step(1'b1, 1'b0, 32'h0);
        check("rd1_drain2_req", {31'b0, s_req}, 32'd0);
        check("rd1_drain2_valid", {31'b0, s_valid}, 32'd0);
        step(1'b1, 1'b0, 32'h0);
        check("rd1_resume_req", {31'b0, s_req}, 32'd1);
        check("rd1_resume_addr", s_addr, 32'h100);
        wait_valid("rd1_first", 32'h100);

        // Redirect coinciding with rvalid and a pop, unaligned target.
        do_reset();
        lat = 1;
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h203);
        check("rd2_pop_valid", {31'b0, s_valid}, 32'd1);
        check("rd2_pop_pc", s_pc, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        check("rd2_flushed_valid", {31'b0, s_valid}, 32'd0);
        check("rd2_flushed_addr", s_addr, 32'h200);
        step(1'b1, 1'b0, 32'h0);
        check("rd2_resume_req", {31'b0, s_req}, 32'd1);
        check("rd2_resume_addr", s_addr, 32'h200);
        wait_valid("rd2_first", 32'h200);

        // PC wrap from the top of the address space.
        do_reset();
        lat    = 1;
        gnt_en = 1'b0;
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        gnt_en = 1'b1;
        step(1'b0, 1'b0, 32'h0);
        check("wrap_req", {31'b0, s_req}, 32'd1);
        check("wrap_addr_top", s_addr, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'h0);
        check("wrap_addr_zero", s_addr, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        check("wrap_pc_top", s_pc, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'h0);
        check("wrap_pc_zero", s_pc, 32'h0);

`ifdef FETCH_CNT_EN
        do_reset();
        lat = 1;
        for (int k = 0; k < 20 && n_accept < 5; k++) step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        check("cnt_five", fetch_cnt, 32'd5);
        step(1'b0, 1'b1, 32'h40);
        step(1'b0, 1'b0, 32'h0);
        check("cnt_after_redirect", fetch_cnt, 32'd5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
